// File: rtl/restoring_div_if.sv
// Handshake and operand/result bundle for the restoring divider.
// The master drives operands and result acceptance; the slave is the divider.
interface restoring_div_if #(
    parameter int WIDTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   div_by_zero;
    logic                   overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/restoring_div.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per cycle, valid/ready on both sides, one operation at a time.
module restoring_div #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    restoring_div_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   part_rem;
    logic [WIDTH-1:0]   dq_sr;
    logic [WIDTH-1:0]   divisor_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   quotient_q;
    logic [WIDTH-1:0]   remainder_q;
    logic               dbz_q;
    logic               ovf_q;
    logic               out_valid_q;

    logic [WIDTH-1:0]   hi_half;
    logic [WIDTH-1:0]   lo_half;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_next;

    assign hi_half = bus.dividend[2*WIDTH-1:WIDTH];
    assign lo_half = bus.dividend[WIDTH-1:0];

    // Since part_rem < divisor is kept as an invariant, diff's top bit is
    // exactly the borrow, so it doubles as the trial-subtraction verdict.
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        trial    = {part_rem, dq_sr[WIDTH-1]};
        diff     = trial - {1'b0, divisor_q};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    // dq_sr shifts dividend low-half bits out of its MSB while quotient bits
    // enter at its LSB; after WIDTH shifts it holds the quotient.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            part_rem    <= '0;
            dq_sr       <= '0;
            divisor_q   <= '0;
            cnt         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= lo_half;
                            dbz_q       <= 1'b1;
                            ovf_q       <= 1'b0;
                            state       <= DONE;
                        end else if (hi_half >= bus.divisor) begin
                            quotient_q  <= '1;
                            remainder_q <= '0;
                            dbz_q       <= 1'b0;
                            ovf_q       <= 1'b1;
                            state       <= DONE;
                        end else begin
                            part_rem  <= hi_half;
                            dq_sr     <= lo_half;
                            divisor_q <= bus.divisor;
                            cnt       <= CNT_W'(WIDTH);
                            state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    part_rem <= rem_next;
                    dq_sr    <= {dq_sr[WIDTH-2:0], q_bit};
                    cnt      <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        quotient_q  <= {dq_sr[WIDTH-2:0], q_bit};
                        remainder_q <= rem_next;
                        dbz_q       <= 1'b0;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // Flag results enter DONE with out_valid low; it rises on
                    // the following edge, giving those paths one cycle latency.
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_restoring_div.sv
// Directed and exhaustive bench for restoring_div at WIDTH=4.
// Expected values come from hand-computed tables and a behavioural a/b, a%b model.
module tb_restoring_div;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [7:0] dd;
        logic [3:0] dv;
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
        logic       ovf;
        int         lat;
    } vec_t;

    restoring_div_if #(.WIDTH(W)) bus ();

    restoring_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present operands at a negedge, hold until in_ready is seen, and return
    // just after the accepting rising edge.
    task automatic accept_op(input logic [7:0] dd, input logic [3:0] dv, output bit ok);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = bus.in_ready;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int cycles, output bit ok);
        cycles = 0;
        while (!bus.out_valid && cycles < max) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        ok = bus.out_valid;
    endtask

    task automatic finish_handshake();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] st;
        #3;
        st = {bus.in_ready, bus.out_valid, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder};
        checks++;
        if (st !== 12'b1000_0000_0000) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", st, 12'b1000_0000_0000);
        end
        @(posedge clk);
        #1;
        st = {bus.in_ready, bus.out_valid, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder};
        checks++;
        if (st !== 12'b1000_0000_0000) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", st, 12'b1000_0000_0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        int cyc;
        bus.out_ready = 1'b1;
        accept_op(8'd100, 4'd7, ok);
        checks++;
        if (!ok || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept: accepted %0d in_ready %b expected accepted 1 in_ready 0", ok, bus.in_ready);
        end
        wait_valid(20, cyc, ok);
        checks++;
        if (!ok || cyc != 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles (valid %0d) expected 4", cyc, ok);
        end
        checks++;
        if (bus.quotient !== 4'd14 || bus.remainder !== 4'd2 || bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%b ovf=%b expected q=14 r=2 dbz=0 ovf=0",
                     bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        finish_handshake();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: got out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_div_by_zero();
        bit ok;
        int cyc;
        bus.out_ready = 1'b1;
        accept_op(8'h35, 4'd0, ok);
        wait_valid(20, cyc, ok);
        checks++;
        if (!ok || cyc != 1) begin
            errors++;
            $display("FAIL dbz_latency: got %0d cycles (valid %0d) expected 1", cyc, ok);
        end
        checks++;
        if (bus.quotient !== 4'hF || bus.remainder !== 4'h5 || bus.div_by_zero !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL dbz_result: got q=%h r=%h dbz=%b ovf=%b expected q=f r=5 dbz=1 ovf=0",
                     bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        finish_handshake();
    endtask

    task automatic test_overflow();
        vec_t tbl[3];
        bit   ok;
        int   cyc;
        tbl[0] = '{8'd200, 4'd3,  4'hF,  4'd0,  1'b0, 1'b1, 1};
        tbl[1] = '{8'd255, 4'd15, 4'hF,  4'd0,  1'b0, 1'b1, 1};
        tbl[2] = '{8'd239, 4'd15, 4'd15, 4'd14, 1'b0, 1'b0, 4};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            accept_op(tbl[i].dd, tbl[i].dv, ok);
            wait_valid(20, cyc, ok);
            checks++;
            if (!ok || cyc != tbl[i].lat || bus.quotient !== tbl[i].q || bus.remainder !== tbl[i].r ||
                bus.div_by_zero !== tbl[i].dbz || bus.overflow !== tbl[i].ovf) begin
                errors++;
                $display("FAIL ovf_vec%0d: got lat=%0d q=%0d r=%0d dbz=%b ovf=%b expected lat=%0d q=%0d r=%0d dbz=%b ovf=%b",
                         i, cyc, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow,
                         tbl[i].lat, tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].ovf);
            end
            finish_handshake();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int cyc;
        bus.out_ready = 1'b0;
        accept_op(8'd77, 4'd5, ok);
        wait_valid(20, cyc, ok);
        checks++;
        if (!ok || bus.quotient !== 4'd15 || bus.remainder !== 4'd2) begin
            errors++;
            $display("FAIL bp_first: got valid=%0d q=%0d r=%0d expected valid=1 q=15 r=2", ok, bus.quotient, bus.remainder);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 4'd9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 4'd15 ||
                bus.remainder !== 4'd2 || bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: got out_valid=%b in_ready=%b q=%0d r=%0d expected 1 0 q=15 r=2",
                         i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_pending_accept: got in_ready=%b expected 0", bus.in_ready);
        end
        wait_valid(20, cyc, ok);
        checks++;
        if (!ok || cyc != 4 || bus.quotient !== 4'd5 || bus.remainder !== 4'd5) begin
            errors++;
            $display("FAIL bp_second: got lat=%0d q=%0d r=%0d expected lat=4 q=5 r=5", cyc, bus.quotient, bus.remainder);
        end
        finish_handshake();
    endtask

    task automatic test_reset_mid_calc();
        bit          ok;
        bit          seen;
        int          cyc;
        logic [11:0] st;
        bus.out_ready = 1'b1;
        accept_op(8'd239, 4'd15, ok);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        st = {bus.in_ready, bus.out_valid, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder};
        checks++;
        if (st !== 12'b1000_0000_0000) begin
            errors++;
            $display("FAIL midreset_async: got %b expected %b", st, 12'b1000_0000_0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_no_result: got out_valid=1 after abort expected 0");
        end
        accept_op(8'd45, 4'd6, ok);
        wait_valid(20, cyc, ok);
        checks++;
        if (!ok || cyc != 4 || bus.quotient !== 4'd7 || bus.remainder !== 4'd3 ||
            bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next: got lat=%0d q=%0d r=%0d dbz=%b ovf=%b expected lat=4 q=7 r=3 0 0",
                     cyc, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        finish_handshake();
    endtask

    task automatic test_exhaustive();
        bit         ok;
        bit         got;
        int         n;
        logic [3:0] eq, er, gq, gr;
        logic       edbz, eovf, gdbz, govf;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    eq = 4'hF; er = 4'(a % 16); edbz = 1'b1; eovf = 1'b0;
                end else if ((a / 16) >= b) begin
                    eq = 4'hF; er = 4'd0; edbz = 1'b0; eovf = 1'b1;
                end else begin
                    eq = 4'(a / b); er = 4'(a % b); edbz = 1'b0; eovf = 1'b0;
                end
                accept_op(8'(a), 4'(b), ok);
                got = 1'b0;
                n = 0;
                gq = '0; gr = '0; gdbz = 1'b0; govf = 1'b0;
                while (!got && n < 100) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    if (bus.out_valid && bus.out_ready) begin
                        got  = 1'b1;
                        gq   = bus.quotient;
                        gr   = bus.remainder;
                        gdbz = bus.div_by_zero;
                        govf = bus.overflow;
                    end
                    n++;
                end
                if (got) begin
                    @(posedge clk);
                    #1;
                end
                checks++;
                if (!ok || !got || gq !== eq || gr !== er || gdbz !== edbz || govf !== eovf) begin
                    errors++;
                    $display("FAIL exh_%0d_%0d: got done=%0d q=%0d r=%0d dbz=%b ovf=%b expected q=%0d r=%0d dbz=%b ovf=%b",
                             a, b, got, gq, gr, gdbz, govf, eq, er, edbz, eovf);
                end
            end
        end
        bus.out_ready = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        test_reset();
        test_basic();
        test_div_by_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid_calc();
        test_exhaustive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
